// File: rtl/uart_pkg.sv
// Shared types for the UART transmit-side blocks: frame format and scheduler states.
package uart_pkg;

    // Per-frame format handed to the UART core alongside the payload.
    typedef struct packed {
        logic [1:0] data_bit_num;
        logic       parity_en;
        logic       parity_type;
        logic       stop_bit_num;
    } uart_frame_cfg_t;

    // Scheduler states: waiting for a request, waiting for the core's ack, frame in flight.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible requester at or
// after ptr_i, wrapping modulo NUM_REQ. Shared with the receive-side schedulers.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] elig;

    // A requester is only a candidate when it asks and its mask bit allows it.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        assign elig[gi] = req_i[gi] & mask_i[gi];
    end

    // Scan from the farthest offset down to offset 0 so the nearest eligible
    // requester to the pointer is the one left in idx_o.
    always_comb begin
        logic [IDX_W-1:0] cand;
        idx_o = '0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (elig[cand]) begin
                idx_o = cand;
            end
        end
        any_o = |elig;
        gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit path between NUM_REQ requesters.
// Each granted frame's payload and format are captured at grant time and held
// on the core-facing outputs until the next grant.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data_i,
    input  uart_frame_cfg_t [NUM_REQ-1:0]     req_cfg_i,
    input  logic [NUM_REQ-1:0]                req_mask_i,
    output logic [NUM_REQ-1:0]                grant_o,
    output logic [NUM_REQ-1:0]                done_o,
    output logic                              start_tx_o,
    output logic [DATA_W-1:0]                 tx_data_o,
    output uart_frame_cfg_t                   cfg_o,
    input  logic                              tx_start_ack_i,
    input  logic                              tx_done_i,
    output logic                              busy_o,
    output logic [IDX_W-1:0]                  owner_o
);

    sched_state_e        state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    uart_frame_cfg_t     cfg_q, cfg_d;
    logic                start_tx_q, start_tx_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  grant_sel;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [IDX_W-1:0]    ptr_after_owner;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i  (req_valid_i),
        .mask_i (req_mask_i),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    // The requester after the finishing owner gets first look next time.
    assign ptr_after_owner = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state logic: arbitration in IDLE, ack wait in START, completion in BUSY.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        tx_data_d  = tx_data_q;
        cfg_d      = cfg_q;
        start_tx_d = start_tx_q;
        done_d     = '0;
        grant_sel  = '0;
        unique case (state_q)
            IDLE: begin
                // A stray tx_done_i here is deliberately ignored.
                if (arb_any) begin
                    grant_sel  = arb_gnt;
                    state_d    = START;
                    tx_data_d  = req_data_i[arb_idx];
                    cfg_d      = req_cfg_i[arb_idx];
                    owner_d    = arb_idx;
                    start_tx_d = 1'b1;
                end
            end
            START: begin
                // No timeout: a CTS-stalled core may hold off the ack indefinitely.
                if (tx_start_ack_i) begin
                    start_tx_d = 1'b0;
                    if (tx_done_i) begin
                        state_d          = IDLE;
                        done_d[owner_q]  = 1'b1;
                        rr_ptr_d         = ptr_after_owner;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (tx_done_i) begin
                    state_d          = IDLE;
                    done_d[owner_q]  = 1'b1;
                    rr_ptr_d         = ptr_after_owner;
                end
            end
            default: begin
                state_d    = IDLE;
                start_tx_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            tx_data_q  <= '0;
            cfg_q      <= '0;
            start_tx_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            tx_data_q  <= tx_data_d;
            cfg_q      <= cfg_d;
            start_tx_q <= start_tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Grant is the requester's capture strobe, so it coincides with the latch edge;
    // it is suppressed while reset is held so no requester believes it was served.
    assign grant_o    = grant_sel & {NUM_REQ{~reset}};
    assign done_o     = done_q;
    assign start_tx_o = start_tx_q;
    assign tx_data_o  = tx_data_q;
    assign cfg_o      = cfg_q;
    assign busy_o     = busy_q;
    assign owner_o    = owner_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: stimulus pushes expected grants/dones into
// queues and an independent monitor pops and compares them as the DUT emits them.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 2;

    logic                             clk;
    logic                             reset;
    logic [NUM_REQ-1:0]               req_valid_i;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_i;
    uart_frame_cfg_t [NUM_REQ-1:0]    req_cfg_i;
    logic [NUM_REQ-1:0]               req_mask_i;
    logic [NUM_REQ-1:0]               grant_o;
    logic [NUM_REQ-1:0]               done_o;
    logic                             start_tx_o;
    logic [DATA_W-1:0]                tx_data_o;
    uart_frame_cfg_t                  cfg_o;
    logic                             tx_start_ack_i;
    logic                             tx_done_i;
    logic                             busy_o;
    logic [IDX_W-1:0]                 owner_o;

    uart_tx_sched #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_cfg_i      (req_cfg_i),
        .req_mask_i     (req_mask_i),
        .grant_o        (grant_o),
        .done_o         (done_o),
        .start_tx_o     (start_tx_o),
        .tx_data_o      (tx_data_o),
        .cfg_o          (cfg_o),
        .tx_start_ack_i (tx_start_ack_i),
        .tx_done_i      (tx_done_i),
        .busy_o         (busy_o),
        .owner_o        (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [4:0]  cfg;
    } exp_t;

    exp_t exp_grant_q[$];
    int   exp_done_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] data_tab [NUM_REQ];
    logic [4:0]  cfg_tab  [NUM_REQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int idx, input logic [31:0] d, input logic [4:0] c, input bit with_done);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        e.cfg  = c;
        exp_grant_q.push_back(e);
        if (with_done) exp_done_q.push_back(idx);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},    32'(grant_o),    32'h0);
        chk({tag, "_done"},     32'(done_o),     32'h0);
        chk({tag, "_start_tx"}, 32'(start_tx_o), 32'h0);
        chk({tag, "_tx_data"},  tx_data_o,       32'h0);
        chk({tag, "_cfg"},      32'(cfg_o),      32'h0);
        chk({tag, "_busy"},     32'(busy_o),     32'h0);
        chk({tag, "_owner"},    32'(owner_o),    32'h0);
    endtask

    task automatic load_table();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data_i[i] = data_tab[i];
            req_cfg_i[i]  = uart_frame_cfg_t'(cfg_tab[i]);
        end
    endtask

    // Plays the transmitter side of one frame: wait for start_tx, hold off the ack,
    // then ack and finish (or ack and finish together when same is set).
    task automatic xmit(input int ack_wait, input int busy_cycles, input bit same);
        int waited;
        bit seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 20) begin
            @(negedge clk);
            if (start_tx_o === 1'b1) seen = 1'b1;
            else waited++;
        end
        chk("start_tx_seen", 32'(seen), 32'h1);
        if (!seen) return;
        for (int k = 0; k < ack_wait; k++) begin
            chk("stall_start_tx", 32'(start_tx_o), 32'h1);
            chk("stall_busy",     32'(busy_o),     32'h1);
            chk("stall_no_grant", 32'(grant_o),    32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        tx_start_ack_i = 1'b1;
        tx_done_i      = same;
        @(posedge clk); #1;
        tx_start_ack_i = 1'b0;
        tx_done_i      = 1'b0;
        @(negedge clk);
        chk("start_tx_low_after_ack", 32'(start_tx_o), 32'h0);
        if (same) begin
            chk("same_cycle_idle", 32'(busy_o), 32'h0);
        end else begin
            chk("busy_after_ack", 32'(busy_o), 32'h1);
            repeat (busy_cycles) @(posedge clk);
            #1 tx_done_i = 1'b1;
            @(posedge clk); #1;
            tx_done_i = 1'b0;
        end
    endtask

    // Scoreboard monitor: compares every grant/done pulse with the queued expectation.
    initial begin
        exp_t cur;
        exp_t e;
        int   di;
        bit   pend;
        bit   have;
        pend = 1'b0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("latched_start_tx", 32'(start_tx_o), 32'h1);
                chk("latched_data",     tx_data_o,       cur.data);
                chk("latched_cfg",      32'(cfg_o),      32'(cur.cfg));
                chk("latched_owner",    32'(owner_o),    32'(cur.idx));
                pend = 1'b0;
            end
            if (done_o !== '0) begin
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", 32'(done_o), 32'h0);
                end else begin
                    di = exp_done_q.pop_front();
                    chk("done_vector", 32'(done_o), 32'(1) << di);
                    if (have) begin
                        chk("data_held_to_done", tx_data_o,  cur.data);
                        chk("cfg_held_to_done",  32'(cfg_o), 32'(cur.cfg));
                    end
                end
                $display("done  vec=%b owner=%0d t=%0t", done_o, owner_o, $time);
            end
            if (grant_o !== '0) begin
                if (exp_grant_q.size() == 0) begin
                    chk("grant_unexpected", 32'(grant_o), 32'h0);
                end else begin
                    e = exp_grant_q.pop_front();
                    chk("grant_vector", 32'(grant_o), 32'(1) << e.idx);
                    cur  = e;
                    have = 1'b1;
                    pend = 1'b1;
                end
                $display("grant vec=%b t=%0t", grant_o, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_tab[i] = 32'hC0DE_0000 | 32'(i * 17 + 1);
            cfg_tab[i]  = 5'(i * 5 + 3);
        end
        reset          = 1'b1;
        req_valid_i    = '0;
        req_mask_i     = '0;
        tx_start_ack_i = 1'b0;
        tx_done_i      = 1'b0;
        load_table();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset      = 1'b0;
        req_mask_i = 4'hF;
        repeat (2) @(posedge clk); #1;

        // Fairness: all valid, pointer starts at 0 -> 0,1,2,3,0.
        for (int k = 0; k < 5; k++) push_frame(k % 4, data_tab[k % 4], cfg_tab[k % 4], 1'b1);
        req_valid_i = 4'hF;
        for (int k = 0; k < 5; k++) begin
            xmit(1, 2, 1'b0);
            if (k == 3) begin
                @(posedge clk); #1;
                req_valid_i = '0;
            end
        end
        repeat (3) @(posedge clk); #1;

        // Single requester 2; its inputs change right after the grant edge.
        push_frame(2, 32'h55, 5'b11100, 1'b1);
        req_valid_i   = 4'b0100;
        req_data_i[2] = 32'h55;
        req_cfg_i[2]  = uart_frame_cfg_t'(5'b11100);
        @(posedge clk); #1;
        req_valid_i   = '0;
        req_data_i[2] = 32'hDEAD_BEEF;
        req_cfg_i[2]  = uart_frame_cfg_t'(5'b00000);
        xmit(3, 2, 1'b0);
        repeat (3) @(posedge clk); #1;

        // Mask 1010 from pointer 3 -> 3,1; mask bit 1 cleared during 1's frame -> 3,3.
        load_table();
        push_frame(3, data_tab[3], cfg_tab[3], 1'b1);
        push_frame(1, data_tab[1], cfg_tab[1], 1'b1);
        push_frame(3, data_tab[3], cfg_tab[3], 1'b1);
        push_frame(3, data_tab[3], cfg_tab[3], 1'b1);
        req_mask_i  = 4'b1010;
        req_valid_i = 4'hF;
        xmit(1, 1, 1'b0);
        @(posedge clk); #1;
        req_mask_i = 4'b1000;
        xmit(1, 3, 1'b0);
        xmit(1, 1, 1'b0);
        @(posedge clk); #1;
        req_valid_i = '0;
        xmit(1, 1, 1'b0);
        repeat (3) @(posedge clk); #1;

        // CTS stall of 100 cycles on requester 0 while others wait, then ack+done together on 1.
        req_mask_i = 4'hF;
        push_frame(0, data_tab[0], cfg_tab[0], 1'b1);
        push_frame(1, data_tab[1], cfg_tab[1], 1'b1);
        req_valid_i = 4'b0001;
        @(posedge clk); #1;
        req_valid_i = 4'b1110;
        xmit(100, 3, 1'b0);
        @(posedge clk); #1;
        req_valid_i = '0;
        xmit(0, 0, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Stray tx_done_i in IDLE.
        tx_done_i = 1'b1;
        @(posedge clk); #1;
        tx_done_i = 1'b0;
        @(negedge clk);
        chk("stray_done_no_pulse", 32'(done_o), 32'h0);
        chk("stray_done_idle",     32'(busy_o), 32'h0);
        repeat (2) @(posedge clk); #1;

        // Reset while BUSY on requester 2 (pointer 2), then pointer must restart at 0.
        push_frame(2, data_tab[2], cfg_tab[2], 1'b0);
        req_valid_i = 4'b0100;
        @(posedge clk); #1;
        req_valid_i    = '0;
        tx_start_ack_i = 1'b1;
        @(posedge clk); #1;
        tx_start_ack_i = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy_o), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid_frame_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        push_frame(0, data_tab[0], cfg_tab[0], 1'b1);
        req_valid_i = 4'hF;
        @(posedge clk); #1;
        req_valid_i = '0;
        xmit(1, 1, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);

        chk("grant_queue_drained", 32'(exp_grant_q.size()), 32'h0);
        chk("done_queue_drained",  32'(exp_done_q.size()),  32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
